// File: rtl/cache_mem_pkg.sv
// Shared types and constants for the cache memory-side responder.
// Optional statistics counters are enabled with `define CACHE_MEM_STATS_EN.
package cache_mem_pkg;

   localparam int CM_WIDTH  = 32;
   localparam int CM_MWIDTH = 32;

   // Default-width write buffer entry; the FIFO re-declares it at its own widths.
   typedef struct packed {
      logic [CM_WIDTH-1:0]  addr;
      logic [CM_MWIDTH-1:0] data;
   } wb_entry_t;

   // Where a served read takes its data from.
   typedef enum logic [1:0] {
      STORE  = 2'd0,
      WB     = 2'd1,
      BYPASS = 2'd2
   } rd_src_e;

   // Pointer width for a buffer of the given depth (at least one bit).
   function automatic int ptr_w(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/cache_wb_fifo.sv
// Posted write buffer: circular FIFO of {addr, data} with a parallel search
// that returns the youngest entry whose full address matches.
module cache_wb_fifo
   import cache_mem_pkg::*;
#(
   parameter int WIDTH    = 32,
   parameter int MWIDTH   = 32,
   parameter int WB_DEPTH = 4,
   parameter int IDX_W    = 12
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              push,
   input  logic [WIDTH-1:0]  push_addr,
   input  logic [MWIDTH-1:0] push_data,
   input  logic              pop,
   output logic [IDX_W-1:0]  head_idx,
   output logic [MWIDTH-1:0] head_data,
   output logic              full,
   output logic              empty,
   input  logic [WIDTH-1:0]  srch_addr,
   output logic              srch_hit,
   output logic [MWIDTH-1:0] srch_data
);

   localparam int PTR_W = ptr_w(WB_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   typedef struct packed {
      logic [WIDTH-1:0]  addr;
      logic [MWIDTH-1:0] data;
   } entry_t;

   entry_t             ent_q [WB_DEPTH];
   logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [PTR_W-1:0]   idx;

   assign full      = (cnt_q == CNT_W'(WB_DEPTH));
   assign empty     = (cnt_q == '0);
   assign head_idx  = ent_q[rd_ptr_q].addr[IDX_W-1:0];
   assign head_data = ent_q[rd_ptr_q].data;

   // Next pointer/count; push and pop are already qualified by the caller.
   always_comb begin
      wr_ptr_d = wr_ptr_q + PTR_W'(push);
      rd_ptr_d = rd_ptr_q + PTR_W'(pop);
      cnt_d    = cnt_q + CNT_W'(push) - CNT_W'(pop);
   end

   // Scan oldest to youngest so the last hit seen is the youngest.
   always_comb begin
      srch_hit  = 1'b0;
      srch_data = '0;
      idx       = '0;
      for (int i = 0; i < WB_DEPTH; i++) begin
         idx = rd_ptr_q + PTR_W'(i);
         if ((CNT_W'(i) < cnt_q) && (ent_q[idx].addr == srch_addr)) begin
            srch_hit  = 1'b1;
            srch_data = ent_q[idx].data;
         end
      end
   end

   // Pointer and occupancy state.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   // Entry storage; contents need no reset since count gates visibility.
   always_ff @(posedge clock) begin
      if (push) ent_q[wr_ptr_q] <= {push_addr, push_data};
   end

endmodule

// File: rtl/cache_mem_responder.sv
// Memory-side responder: registered reads with write-buffer forwarding,
// posted writes drained into a single-port store in idle read cycles, and a
// starvation counter that forces a drain after STARVE_MAX deferrals.
// Optional statistics outputs: `define CACHE_MEM_STATS_EN.
module cache_mem_responder
   import cache_mem_pkg::*;
#(
   parameter int WIDTH      = 32,
   parameter int MWIDTH     = 32,
   parameter int DEPTH_LOG2 = 12,
   parameter int WB_DEPTH   = 4,
   parameter int STARVE_MAX = 8
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              mrden,
   input  logic [WIDTH-1:0]  mrdaddress,
   input  logic              mwren,
   input  logic [WIDTH-1:0]  mwraddress,
   input  logic [MWIDTH-1:0] mdout,
   output logic [MWIDTH-1:0] mq,
   output logic              mq_valid,
   output logic              wb_full,
   output logic              wb_overflow
`ifdef CACHE_MEM_STATS_EN
   ,
   output logic [31:0]       stat_rd,
   output logic [31:0]       stat_wr,
   output logic [31:0]       stat_fwd,
   output logic [31:0]       stat_stall
`endif
);

   localparam int SW = $clog2(STARVE_MAX + 1);

   logic [MWIDTH-1:0]     store_q [2**DEPTH_LOG2];
   logic [MWIDTH-1:0]     mq_q, mq_d, rd_data, wb_data, head_data;
   logic                  mq_valid_q, mq_valid_d, ovf_q, ovf_d;
   logic [SW-1:0]         starve_q, starve_d;
   logic [DEPTH_LOG2-1:0] head_idx;
   logic                  full, empty, wb_hit, pop, push, forced, served;
   rd_src_e               src;

   cache_wb_fifo #(
      .WIDTH(WIDTH), .MWIDTH(MWIDTH), .WB_DEPTH(WB_DEPTH), .IDX_W(DEPTH_LOG2)
   ) u_fifo (
      .clock(clock), .reset(reset),
      .push(push), .push_addr(mwraddress), .push_data(mdout),
      .pop(pop), .head_idx(head_idx), .head_data(head_data),
      .full(full), .empty(empty),
      .srch_addr(mrdaddress), .srch_hit(wb_hit), .srch_data(wb_data)
   );

   assign mq          = mq_q;
   assign mq_valid    = mq_valid_q;
   assign wb_full     = full;
   assign wb_overflow = ovf_q;

   // Drain arbitration, read source select and next-state for all registers.
   always_comb begin
      forced = !empty && mrden && (starve_q == SW'(STARVE_MAX));
      pop    = !empty && (!mrden || (starve_q == SW'(STARVE_MAX)));
      served = mrden && !forced;
      // A full buffer still accepts a write when the head leaves this cycle.
      push   = mwren && (!full || pop);

      if (mwren && (mwraddress == mrdaddress)) src = BYPASS;
      else if (wb_hit)                         src = WB;
      else                                     src = STORE;

      case (src)
         BYPASS:  rd_data = mdout;
         WB:      rd_data = wb_data;
         default: rd_data = store_q[mrdaddress[DEPTH_LOG2-1:0]];
      endcase

      mq_d       = served ? rd_data : mq_q;
      mq_valid_d = served;
      ovf_d      = ovf_q | (mwren & ~push);

      if (empty || pop)                          starve_d = '0;
      else if (starve_q < SW'(STARVE_MAX))       starve_d = starve_q + SW'(1);
      else                                       starve_d = starve_q;
   end

   // Output, sticky flag and starvation state.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         mq_q       <= '0;
         mq_valid_q <= 1'b0;
         ovf_q      <= 1'b0;
         starve_q   <= '0;
      end else begin
         mq_q       <= mq_d;
         mq_valid_q <= mq_valid_d;
         ovf_q      <= ovf_d;
         starve_q   <= starve_d;
      end
   end

   // Backing store write port; reads and drains never share a cycle.
   always_ff @(posedge clock) begin
      if (pop) store_q[head_idx] <= head_data;
   end

`ifdef CACHE_MEM_STATS_EN
   logic [31:0] stat_rd_q, stat_wr_q, stat_fwd_q, stat_stall_q;

   // Wrapping event counters.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         stat_rd_q    <= '0;
         stat_wr_q    <= '0;
         stat_fwd_q   <= '0;
         stat_stall_q <= '0;
      end else begin
         stat_rd_q    <= stat_rd_q + 32'(served);
         stat_wr_q    <= stat_wr_q + 32'(push);
         stat_fwd_q   <= stat_fwd_q + 32'(served && (src != STORE));
         stat_stall_q <= stat_stall_q + 32'(forced);
      end
   end

   assign stat_rd    = stat_rd_q;
   assign stat_wr    = stat_wr_q;
   assign stat_fwd   = stat_fwd_q;
   assign stat_stall = stat_stall_q;
`endif

endmodule

// File: tb/tb_cache_mem_responder.sv
// Directed bench for cache_mem_responder: stimulus pushes the expected
// {mq_valid, mq} of every clocked cycle into a queue; a monitor on the
// falling edge pops and compares.
module tb_cache_mem_responder;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        mrden = 1'b0;
   logic [31:0] mrdaddress = '0;
   logic        mwren = 1'b0;
   logic [31:0] mwraddress = '0;
   logic [31:0] mdout = '0;
   logic [31:0] mq;
   logic        mq_valid, wb_full, wb_overflow;
`ifdef CACHE_MEM_STATS_EN
   logic [31:0] stat_rd, stat_wr, stat_fwd, stat_stall;
`endif

   cache_mem_responder dut (
      .clock(clock), .reset(reset),
      .mrden(mrden), .mrdaddress(mrdaddress),
      .mwren(mwren), .mwraddress(mwraddress), .mdout(mdout),
      .mq(mq), .mq_valid(mq_valid), .wb_full(wb_full), .wb_overflow(wb_overflow)
`ifdef CACHE_MEM_STATS_EN
      , .stat_rd(stat_rd), .stat_wr(stat_wr), .stat_fwd(stat_fwd), .stat_stall(stat_stall)
`endif
   );

   always #5 clock = ~clock;

   typedef struct {
      logic        v;
      logic [31:0] d;
      int          n;
   } exp_t;

   exp_t        exp_q[$];
   int          checks = 0;
   int          failures = 0;
   int          stepno = 0;
   logic [31:0] last_mq = '0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
      checks++;
      if (act !== want) begin
         failures++;
         $display("FAIL %s: got %h want %h", nm, act, want);
      end
   endtask

   // Monitor: compare each clocked cycle's result away from the rising edge.
   always @(negedge clock) begin
      exp_t e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         checks++;
         if (mq_valid !== e.v || mq !== e.d) begin
            failures++;
            $display("FAIL step%0d: got valid=%b mq=%h want valid=%b mq=%h",
                     e.n, mq_valid, mq, e.v, e.d);
         end
      end
   end

   // One clocked cycle; srv says whether the read is served with data ed.
   task automatic step(input logic rd, input logic [31:0] ra, input logic wr,
                       input logic [31:0] wa, input logic [31:0] wd,
                       input logic srv, input logic [31:0] ed);
      exp_t e;
      mrden = rd; mrdaddress = ra; mwren = wr; mwraddress = wa; mdout = wd;
      @(posedge clock);
      if (srv) last_mq = ed;
      e.v = srv; e.d = last_mq; e.n = stepno++;
      exp_q.push_back(e);
      #1;
      mrden = 1'b0; mwren = 1'b0;
   endtask

   task automatic rd(input logic [31:0] a, input logic [31:0] ed);
      step(1'b1, a, 1'b0, 32'h0, 32'h0, 1'b1, ed);
   endtask

   task automatic idle();
      step(1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
   endtask

   initial begin
      repeat (2) @(posedge clock);
      #1;
      chk("rst_mq", mq, 32'h0);
      chk("rst_valid", {31'b0, mq_valid}, 32'h0);
      chk("rst_full", {31'b0, wb_full}, 32'h0);
      chk("rst_ovf", {31'b0, wb_overflow}, 32'h0);
      reset = 1'b0;

      // Preload store[0x10] through the buffer, then read it back.
      step(1'b0, 32'h0, 1'b1, 32'h10, 32'hA5A5A5A5, 1'b0, 32'h0);
      idle();
      rd(32'h10, 32'hA5A5A5A5);

      // Same-cycle bypass, then the drained value from the store.
      step(1'b1, 32'h20, 1'b1, 32'h20, 32'h1234, 1'b1, 32'h1234);
      idle();
      rd(32'h20, 32'h1234);

      // Youngest-entry forwarding.
      step(1'b1, 32'h10, 1'b1, 32'h30, 32'h1, 1'b1, 32'hA5A5A5A5);
      step(1'b1, 32'h10, 1'b1, 32'h30, 32'h2, 1'b1, 32'hA5A5A5A5);
      rd(32'h30, 32'h2);
      idle();
      idle();
      rd(32'h30, 32'h2);

      // Starvation: two entries, forced drain after 8 deferrals, counter clears.
      step(1'b1, 32'h10, 1'b1, 32'h40, 32'h55, 1'b1, 32'hA5A5A5A5);
      step(1'b1, 32'h10, 1'b1, 32'h44, 32'h66, 1'b1, 32'hA5A5A5A5);
      for (int i = 0; i < 7; i++) rd(32'h10, 32'hA5A5A5A5);
      step(1'b1, 32'h10, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
      for (int i = 0; i < 8; i++) rd(32'h44, 32'h66);
      step(1'b1, 32'h44, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
      rd(32'h40, 32'h55);
      rd(32'h44, 32'h66);

      // Fill, overflow, sticky flag, push-while-full with pop.
      for (int i = 0; i < 4; i++)
         step(1'b1, 32'h10, 1'b1, 32'h50 + i, 32'h50 + i, 1'b1, 32'hA5A5A5A5);
      chk("full4", {31'b0, wb_full}, 32'h1);
      chk("ovf_before", {31'b0, wb_overflow}, 32'h0);
      step(1'b1, 32'h10, 1'b1, 32'h54, 32'h99, 1'b1, 32'hA5A5A5A5);
      chk("ovf_set", {31'b0, wb_overflow}, 32'h1);
      chk("full_keep", {31'b0, wb_full}, 32'h1);
      rd(32'h52, 32'h52);
      step(1'b0, 32'h0, 1'b1, 32'h55, 32'h77, 1'b0, 32'h0);
      chk("ovf_sticky", {31'b0, wb_overflow}, 32'h1);
      chk("full_pushpop", {31'b0, wb_full}, 32'h1);

      // Asynchronous reset mid-operation.
      @(negedge clock);
      #1 reset = 1'b1;
      #1;
      chk("mid_rst_mq", mq, 32'h0);
      chk("mid_rst_valid", {31'b0, mq_valid}, 32'h0);
      chk("mid_rst_full", {31'b0, wb_full}, 32'h0);
      chk("mid_rst_ovf", {31'b0, wb_overflow}, 32'h0);
      exp_q.delete();
      last_mq = '0;
      @(negedge clock);
      #2 reset = 1'b0;
      @(posedge clock);
      #1;

      // Store survives reset; buffer does not.
      rd(32'h50, 32'h50);
      rd(32'h10, 32'hA5A5A5A5);
      idle();
      chk("post_rst_full", {31'b0, wb_full}, 32'h0);

      for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clock);
      #1;
      if (exp_q.size() != 0) begin
         checks++;
         failures++;
         $display("FAIL drain_timeout: got %0d pending want 0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
